alu_exec_unit: RTL and testbench

- Iterative ALU execute stage; the consumer end of the 4-bit ALU control code produced by the ALU control decoder.
- Accepts one operation (control code plus two operands) through a valid/ready handshake and returns the result through a second valid/ready handshake.
- Logic and arithmetic ops complete in 1 cycle. Shifts run 1 bit per cycle to avoid a barrel shifter.
- Sits between the register-read/operand-mux stage and writeback / branch-resolve in the multi-cycle core.

---
 rtl/alu_exec_unit.sv | 134 +++++++++++++
 tb/tb_alu_exec_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Iterative ALU execute stage: single-cycle logic/arith ops, shifts at one bit per cycle.
// One op in flight; valid/ready handshake on both the request and the result side.
module alu_exec_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int unsigned ShW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [ShW-1:0]    count_q, count_d;
    logic [1:0]        shop_q, shop_d;
    logic              zero_q, zero_d;
    logic              illegal_q, illegal_d;

    logic [ShW-1:0]    shamt;
    logic              is_shift;
    logic              bad_code;
    logic [XLEN-1:0]   alu_val;
    logic [XLEN-1:0]   shifted;

    assign shamt = op_b[ShW-1:0];

    // Single-cycle datapath; shift codes pass op_a through for the shamt == 0 case.
    always_comb begin
        alu_val  = '0;
        is_shift = 1'b0;
        bad_code = 1'b0;
        case (alu_ctrl)
            4'b0000: alu_val = op_a & op_b;
            4'b0001: alu_val = op_a | op_b;
            4'b0010: alu_val = op_a + op_b;
            4'b0011: alu_val = op_a ^ op_b;
            4'b0100, 4'b0101, 4'b0111: begin
                alu_val  = op_a;
                is_shift = 1'b1;
            end
            4'b0110: alu_val = op_a - op_b;
            4'b1000: alu_val = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'b1001: alu_val = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            default: bad_code = 1'b1;
        endcase
    end

    // shop_q holds alu_ctrl[1:0]: 00 SLL, 01 SRL, 11 SRA.
    always_comb begin
        case (shop_q)
            2'b00:   shifted = {acc_q[XLEN-2:0], 1'b0};
            2'b01:   shifted = {1'b0, acc_q[XLEN-1:1]};
            default: shifted = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        count_d   = count_q;
        shop_d    = shop_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    shop_d = alu_ctrl[1:0];
                    if (is_shift && (shamt != '0)) begin
                        acc_d     = op_a;
                        count_d   = shamt;
                        illegal_d = 1'b0;
                        state_d   = StShift;
                    end else begin
                        acc_d     = alu_val;
                        zero_d    = (alu_val == '0);
                        illegal_d = bad_code;
                        state_d   = StDone;
                    end
                end
            end
            StShift: begin
                acc_d   = shifted;
                count_d = count_q - 1'b1;
                if (count_q == ShW'(1)) begin
                    zero_d  = (shifted == '0);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            count_q   <= '0;
            shop_q    <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            shop_q    <= shop_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = acc_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (XLEN = 32).
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int checks = 0;
    int passes = 0;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an op until accepted; returns in cycle T+1.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk("issue_timeout", 64'd1, 64'd0);
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic [31:0] r, input logic z,
                              input logic il);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_result"}, result, r);
        chk({tag, "_zero"}, zero, z);
        chk({tag, "_illegal"}, illegal, il);
        chk({tag, "_busy"}, in_ready, 1'b0);
        out_ready = 1'b1;
        step();
        chk({tag, "_idle"}, in_ready, 1'b1);
        chk({tag, "_drop"}, out_valid, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_ctrl  = 4'h0;
        op_a      = '0;
        op_b      = '0;
        step();
        step();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, 32'h0);
        chk("rst_zero", zero, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", in_ready, 1'b1);

        issue(4'b0010, 32'hFFFF_FFFF, 32'h0000_0002);
        expect_res("add_wrap", 32'h0000_0001, 1'b0, 1'b0);

        issue(4'b0110, 32'h1234_5678, 32'h1234_5678);
        expect_res("sub_eq", 32'h0, 1'b1, 1'b0);

        issue(4'b1000, 32'hFFFF_FFFF, 32'h0000_0001);
        expect_res("slt", 32'h1, 1'b0, 1'b0);

        issue(4'b1001, 32'hFFFF_FFFF, 32'h0000_0001);
        expect_res("sltu", 32'h0, 1'b1, 1'b0);

        issue(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00);
        expect_res("and", 32'h00F0_1200, 1'b0, 1'b0);

        issue(4'b0001, 32'hF000_0001, 32'h0000_0F00);
        expect_res("or", 32'hF000_0F01, 1'b0, 1'b0);

        // SRA by 5: busy for T+1..T+5, result at T+6.
        issue(4'b0111, 32'h8000_0000, 32'hFFFF_FFE5);
        for (int i = 1; i <= 5; i++) begin
            chk("sra_busy_ready", in_ready, 1'b0);
            chk("sra_busy_valid", out_valid, 1'b0);
            step();
        end
        expect_res("sra5", 32'hFC00_0000, 1'b0, 1'b0);

        // Upper op_b bits set but shamt field zero.
        issue(4'b0100, 32'hA5A5_0F0F, 32'h0000_0020);
        expect_res("sll0", 32'hA5A5_0F0F, 1'b0, 1'b0);

        issue(4'b0101, 32'h8000_0000, 32'h0000_001F);
        for (int i = 1; i <= 31; i++) begin
            chk("srl31_busy", out_valid, 1'b0);
            step();
        end
        expect_res("srl31", 32'h0000_0001, 1'b0, 1'b0);

        issue(4'b0100, 32'h0000_0003, 32'h0000_0004);
        for (int i = 1; i <= 4; i++) step();
        expect_res("sll4", 32'h0000_0030, 1'b0, 1'b0);

        // Backpressure: XOR result held while a new op waits on the inputs.
        out_ready = 1'b0;
        issue(4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        alu_ctrl = 4'b0010;
        op_a     = 32'h3;
        op_b     = 32'h4;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_result", result, 32'hFF00_FF00);
            chk("bp_zero", zero, 1'b0);
            chk("bp_ready", in_ready, 1'b0);
            step();
        end
        chk("bp_still_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        step();
        chk("bp_idle_ready", in_ready, 1'b1);
        chk("bp_idle_valid", out_valid, 1'b0);
        step();
        in_valid = 1'b0;
        expect_res("bp_pending_add", 32'h0000_0007, 1'b0, 1'b0);

        issue(4'b1100, 32'h1234_5678, 32'h9ABC_DEF0);
        expect_res("illegal", 32'h0, 1'b1, 1'b1);

        // Reset during SLL by 20 abandons the op.
        issue(4'b0100, 32'h0000_0001, 32'h0000_0014);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_result", result, 32'h0);
        for (int i = 0; i < 25; i++) begin
            chk("mid_rst_no_out", out_valid, 1'b0);
            step();
        end
        chk("mid_rst_ready", in_ready, 1'b1);
        issue(4'b0010, 32'h0000_0005, 32'h0000_0006);
        expect_res("post_rst_add", 32'h0000_000B, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
